sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-port 32x16 SRAM.
- Port 0 is the CPU memory interface; port 1 is the program loader/debug port.
- Serialises requests into SRAM cycles, drives the active-low write enable, and absorbs the SRAM's one-cycle registered read latency.
- Returns read data per port with a one-cycle valid pulse; out-of-range addresses are blocked and flagged.

Parameters:
- DATA_W, 16, data width of requesters and SRAM.
- ADDR_W, 16, address width of requesters and SRAM.
- DEPTH, 32, number of implemented SRAM words; an address >= DEPTH is out of range.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0 / req1  input  1  request from port 0 / 1; held until gnt of that port is seen.
- we0 / we1  input  1  1 = write, 0 = read; held with req.
- addr0 / addr1  input  ADDR_W  word address; held with req.
- wdata0 / wdata1  input  DATA_W  write data; held with req.
- gnt0 / gnt1  output  1  one-cycle pulse: request accepted, SRAM cycle in progress.
- rvalid0 / rvalid1  output  1  one-cycle pulse: rdata of that port valid.
- rdata0 / rdata1  output  DATA_W  read data; holds last value between pulses.
- err0 / err1  output  1  one-cycle pulse with gnt: address was out of range.
- busy  output  1  high whenever state != IDLE.
- mem_we_n  output  1  to SRAM we_n; active low.
- mem_addr  output  ADDR_W  to SRAM addr.
- mem_din  output  DATA_W  to SRAM data_in.
- mem_dout  input  DATA_W  from SRAM data_out; valid in the cycle after the access edge.

Behaviour:
- All outputs are registered.
- Reset values:
  - gnt*, rvalid*, err*, busy = 0.
  - rdata* = 0.
  - mem_we_n = 1.
  - mem_addr = 0, mem_din = 0.
  - state = IDLE; rr pointer = last granted port 1, so port 0 wins the first tie.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any req is high: pick a winner (a single requester wins; if both, the port not granted last wins).
  - At the edge, register mem_addr = addr_w and mem_din = wdata_w.
  - mem_we_n = ~we_w, but forced to 1 if addr_w >= DEPTH.
  - Also register gnt_w = 1, err_w = (addr_w >= DEPTH), update rr pointer, go to ACCESS.
- ACCESS (one cycle; the SRAM samples at the closing edge):
  - At that edge: gnt, err <= 0; mem_we_n <= 1.
  - Write: go to IDLE.
  - Read: go to RESP.
- RESP (one cycle; mem_dout holds the read word):
  - At the edge: rdata_w <= mem_dout, or 0 if the access was out of range.
  - rvalid_w <= 1; go to IDLE.
- Latency, with N = first cycle req is high in IDLE:
  - gnt is visible in cycle N+1.
  - A write commits at the end of N+1.
  - Read data and rvalid are visible in N+3.
- Throughput: a write occupies 2 cycles, a read 3 cycles. In the rvalid cycle the arbiter is in IDLE and may accept the next request.
- Requesters react to gnt with registered logic: req drops no later than the cycle after gnt. A req still high in IDLE is a new transaction.
- An out-of-range write never asserts mem_we_n = 0.
- An out-of-range read still walks RESP and returns 0 with rvalid = 1.
- Only one gnt / rvalid / err bit is ever high at a time; both ports are never granted together.
- Reset mid-operation:
  - The state machine returns to IDLE and no rvalid is produced for the aborted read.
  - A write whose ACCESS cycle coincides with the reset edge still lands in the SRAM, since the SRAM itself is not reset.
- mem_addr / mem_din keep their last value after an access; only mem_we_n returns to 1.

Decomposition:
- Shared package mano_mem_pkg:
  - DATA_W, ADDR_W, DEPTH constants.
  - arb_state_t enum {IDLE, ACCESS, RESP}.
  - port id typedef (1 bit).
- One sub-module, rr_arb2: a 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Output: one-hot grant.
  - Purely combinational; pointer state lives in sram_arbiter.

Test Plan:
- Port 0 writes addr 5 = 16'hBEEF, then reads addr 5 -> gnt0 in N+1, mem_we_n low exactly one cycle; rvalid0 in N+3 with rdata0 = 16'hBEEF.
- req0 and req1 both rise in the same cycle after reset (reads of addr 1 and 2, preloaded 16'h1111 / 16'h2222):
  - port 0 granted first, port 1 next;
  - rdata0 = 16'h1111, rdata1 = 16'h2222;
  - gnt0/gnt1 never overlap.
- Both ports request continuously for 6 transactions -> grants strictly alternate 0,1,0,1,0,1.
- Port 1 writes addr 40 = 16'h1234 -> err1 pulses with gnt1, mem_we_n stays 1, addr 8 (alias) unchanged. A following read of addr 40 returns rvalid1 with rdata1 = 0 and err1 = 1.
- Back-to-back: a port 0 read of addr 3, with a port 1 write queued -> gnt1 is issued the cycle after rvalid0 (no idle gap beyond IDLE).
- rst asserted during RESP of a port 0 read -> no rvalid0; all outputs at reset values next cycle; busy = 0.

Source files
------------

// File: rtl/mano_mem_pkg.sv
// Shared definitions for the SRAM arbiter slice.
//   DATA_W / ADDR_W : requester and SRAM data/address widths
//   DEPTH           : implemented SRAM words; any address >= DEPTH is out of range
//   arb_state_t     : sequencer states (IDLE -> ACCESS [-> RESP] -> IDLE)
//   port_id_t       : identifies requester 0 (CPU) or 1 (loader/debug)
package mano_mem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin picker (purely combinational).
//   req_i  [1:0] : request vector, bit n = port n
//   last_i       : port granted most recently
//   gnt_o  [1:0] : one-hot grant; all zero when nothing requests
// On a tie the port that was not granted last wins.
module rr_arb2
  import mano_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_id_t   last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of a single-port
// SRAM with a one-cycle registered read.
//   clk, rst                   : clock, synchronous active-high reset
//   req*/we*/addr*/wdata*      : requester inputs, held until that port's gnt
//   gnt*                       : one-cycle pulse, request accepted
//   err*                       : pulses with gnt when the address is out of range
//   rvalid*/rdata*             : read return; rdata holds between pulses
//   busy                       : sequencer not in IDLE
//   mem_we_n/mem_addr/mem_din  : SRAM control/address/write data
//   mem_dout                   : SRAM read data, valid the cycle after the access edge
//   state_dbg                  : current sequencer state
// Handshake: a requester raises req with we/addr/wdata stable and keeps them
// until it sees its gnt pulse; req must be low by the cycle after gnt, since a
// req still high when the sequencer is back in IDLE starts a new transaction.
// All outputs are registered.
module sram_arbiter #(
  parameter int DATA_W = mano_mem_pkg::DATA_W,
  parameter int ADDR_W = mano_mem_pkg::ADDR_W,
  parameter int DEPTH  = mano_mem_pkg::DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       addr0,
  input  logic [ADDR_W-1:0]       addr1,
  input  logic [DATA_W-1:0]       wdata0,
  input  logic [DATA_W-1:0]       wdata1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    rvalid0,
  output logic                    rvalid1,
  output logic [DATA_W-1:0]       rdata0,
  output logic [DATA_W-1:0]       rdata1,
  output logic                    err0,
  output logic                    err1,
  output logic                    busy,
  output logic                    mem_we_n,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_din,
  input  logic [DATA_W-1:0]       mem_dout,
  output mano_mem_pkg::arb_state_t state_dbg
);

  import mano_mem_pkg::*;

  arb_state_t        state_q, state_d;
  port_id_t          last_q, last_d;   // last granted port
  port_id_t          cur_q, cur_d;     // port owning the cycle in flight
  logic              wr_q, wr_d;       // cycle in flight is a write
  logic              oor_q, oor_d;     // cycle in flight is out of range
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        err_q, err_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              busy_q, busy_d;
  logic              mem_we_n_q, mem_we_n_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;

  logic [1:0]        pick;
  logic              any_pick;
  port_id_t          win;
  logic              we_w;
  logic [ADDR_W-1:0] addr_w;
  logic [DATA_W-1:0] wdata_w;
  logic              oor_w;

  rr_arb2 u_rr (
    .req_i  ({req1, req0}),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  // Winner's request fields, only meaningful while any_pick is high.
  assign any_pick = |pick;
  assign win      = pick[1];
  assign we_w     = win ? we1    : we0;
  assign addr_w   = win ? addr1  : addr0;
  assign wdata_w  = win ? wdata1 : wdata0;
  assign oor_w    = (addr_w >= ADDR_W'(DEPTH));

  // State register (plus all registered outputs)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;   // port 0 wins the first tie
      cur_q      <= 1'b0;
      wr_q       <= 1'b0;
      oor_q      <= 1'b0;
      gnt_q      <= '0;
      err_q      <= '0;
      rvalid_q   <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      busy_q     <= 1'b0;
      mem_we_n_q <= 1'b1;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cur_q      <= cur_d;
      wr_q       <= wr_d;
      oor_q      <= oor_d;
      gnt_q      <= gnt_d;
      err_q      <= err_d;
      rvalid_q   <= rvalid_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      busy_q     <= busy_d;
      mem_we_n_q <= mem_we_n_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_pick) state_d = ACCESS;
      ACCESS:  state_d = wr_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values. Pulses (gnt, err, rvalid) and the write
  // strobe default to their idle level so each lasts exactly one cycle.
  always_comb begin
    last_d     = last_q;
    cur_d      = cur_q;
    wr_d       = wr_q;
    oor_d      = oor_q;
    gnt_d      = '0;
    err_d      = '0;
    rvalid_d   = '0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    mem_we_n_d = 1'b1;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    busy_d     = (state_d != IDLE);

    case (state_q)
      IDLE: begin
        if (any_pick) begin
          mem_addr_d   = addr_w;
          mem_din_d    = wdata_w;
          // Out-of-range writes must never strobe the SRAM (it would alias).
          mem_we_n_d   = ~we_w | oor_w;
          gnt_d[win]   = 1'b1;
          err_d[win]   = oor_w;
          last_d       = win;
          cur_d        = win;
          wr_d         = we_w;
          oor_d        = oor_w;
        end
      end
      RESP: begin
        // Out-of-range reads complete normally but return zero.
        rvalid_d[cur_q] = 1'b1;
        if (cur_q) rdata1_d = oor_q ? '0 : mem_dout;
        else       rdata0_d = oor_q ? '0 : mem_dout;
      end
      default: ;
    endcase
  end

  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign err0      = err_q[0];
  assign err1      = err_q[1];
  assign rvalid0   = rvalid_q[0];
  assign rvalid1   = rvalid_q[1];
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = busy_q;
  assign mem_we_n  = mem_we_n_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  import mano_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy, mem_we_n;
  logic [15:0] rdata0, rdata1, mem_addr, mem_din;
  logic [15:0] mem_dout = '0;
  arb_state_t  state_dbg;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .busy(busy), .mem_we_n(mem_we_n), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .state_dbg(state_dbg)
  );

  // ---------------- SRAM model (32x16, registered read, not reset) ----------------
  logic [15:0] sram [0:31] = '{1: 16'h1111, 2: 16'h2222, 3: 16'h3333,
                               8: 16'h0808, default: 16'h0000};
  always @(posedge clk) begin
    if (!mem_we_n) sram[mem_addr[4:0]] <= mem_din;
    mem_dout <= sram[mem_addr[4:0]];
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int we_low_cnt = 0;
  logic mon_en = 0;
  logic [0:0]  gnt_exp_q[$];
  logic [15:0] rd0_exp_q[$];
  logic [15:0] rd1_exp_q[$];
  int rv0_cyc, g1_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-hot properties checked every cycle, plus write-strobe counting.
  always @(negedge clk) begin
    if (!mem_we_n) we_low_cnt++;
    if (mon_en) begin
      chk("onehot_gnt", {31'd0, gnt0 & gnt1}, 32'd0);
      chk("onehot_rvalid", {31'd0, rvalid0 & rvalid1}, 32'd0);
      chk("err_without_gnt", {31'd0, (err0 & ~gnt0) | (err1 & ~gnt1)}, 32'd0);
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_gnt"}, {gnt1, gnt0}, 0);
    chk({tag, "_rvalid"}, {rvalid1, rvalid0}, 0);
    chk({tag, "_err"}, {err1, err0}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdata0"}, rdata0, 0);
    chk({tag, "_rdata1"}, rdata1, 0);
    chk({tag, "_we_n"}, mem_we_n, 1);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_din"}, mem_din, 0);
    chk({tag, "_state"}, state_dbg, IDLE);
  endtask

  // ---------------- driver: one isolated transaction ----------------
  // Starts and ends on a negedge; req raised here is sampled at the next
  // posedge (end of cycle N).
  task automatic do_txn(input string name, input logic p, input logic w,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] ex_rd, input logic ex_err);
    int wl0;
    wl0 = we_low_cnt;
    if (!p) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    else    begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    @(negedge clk); // N+1
    chk({name, "_gnt"}, p ? gnt1 : gnt0, 1);
    chk({name, "_gnt_other"}, p ? gnt0 : gnt1, 0);
    chk({name, "_err"}, p ? err1 : err0, ex_err);
    chk({name, "_mem_addr"}, mem_addr, a);
    chk({name, "_mem_din"}, mem_din, d);
    chk({name, "_we_n"}, mem_we_n, (w && !ex_err) ? 0 : 1);
    chk({name, "_busy"}, busy, 1);
    if (!p) req0 = 0; else req1 = 0;
    @(negedge clk); // N+2
    chk({name, "_gnt_drop"}, {gnt1, gnt0}, 0);
    chk({name, "_we_n_rel"}, mem_we_n, 1);
    if (w) begin
      chk({name, "_we_pulses"}, we_low_cnt - wl0, ex_err ? 0 : 1);
      chk({name, "_busy_done"}, busy, 0);
    end else begin
      chk({name, "_rvalid_early"}, {rvalid1, rvalid0}, 0);
      @(negedge clk); // N+3
      chk({name, "_rvalid"}, p ? rvalid1 : rvalid0, 1);
      chk({name, "_rvalid_other"}, p ? rvalid0 : rvalid1, 0);
      chk({name, "_rdata"}, p ? rdata1 : rdata0, ex_rd);
      chk({name, "_busy_done"}, busy, 0);
      @(negedge clk);
      chk({name, "_rvalid_pulse"}, p ? rvalid1 : rvalid0, 0);
      chk({name, "_rdata_hold"}, p ? rdata1 : rdata0, ex_rd);
    end
  endtask

  // ---------------- driver: registered requesters with pending counts ----------------
  // Each requester drops req for the cycle after seeing its gnt, then
  // re-raises it while transactions remain.
  task automatic run_seq(input string name, input int n0, input int n1,
                         input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                         input logic w1, input logic [15:0] a1, input logic [15:0] d1,
                         input int budget);
    int  p0, p1;
    logic done;
    logic [0:0] e;
    logic [15:0] ed;
    p0 = n0; p1 = n1; done = 0;
    rv0_cyc = -1; g1_cyc = -1;
    we0 = w0; addr0 = a0; wdata0 = d0;
    we1 = w1; addr1 = a1; wdata1 = d1;
    req0 = (p0 > 0); req1 = (p1 > 0);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (gnt0 | gnt1) begin
        if (gnt_exp_q.size() == 0) chk({name, "_extra_gnt"}, 1, 0);
        else begin e = gnt_exp_q.pop_front(); chk({name, "_gnt_order"}, gnt1, e); end
      end
      if (rvalid0) begin
        rv0_cyc = c;
        if (rd0_exp_q.size() == 0) chk({name, "_extra_rvalid0"}, 1, 0);
        else begin ed = rd0_exp_q.pop_front(); chk({name, "_rdata0"}, rdata0, ed); end
      end
      if (rvalid1) begin
        if (rd1_exp_q.size() == 0) chk({name, "_extra_rvalid1"}, 1, 0);
        else begin ed = rd1_exp_q.pop_front(); chk({name, "_rdata1"}, rdata1, ed); end
      end
      if (gnt1 && g1_cyc < 0) g1_cyc = c;
      if (gnt0) begin p0--; req0 = 0; end else req0 = (p0 > 0);
      if (gnt1) begin p1--; req1 = 0; end else req1 = (p1 > 0);
      if (p0 <= 0 && p1 <= 0 && gnt_exp_q.size() == 0 && rd0_exp_q.size() == 0 &&
          rd1_exp_q.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    req0 = 0; req1 = 0;
    chk({name, "_completed_in_budget"}, done, 1);
    gnt_exp_q.delete(); rd0_exp_q.delete(); rd1_exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[10];

  initial begin
    vecs[0] = '{"p0_wr5",    1'b0, 1'b1, 16'd5,  16'hBEEF, 16'h0000, 1'b0};
    vecs[1] = '{"p0_rd5",    1'b0, 1'b0, 16'd5,  16'h0000, 16'hBEEF, 1'b0};
    vecs[2] = '{"p1_wr40",   1'b1, 1'b1, 16'd40, 16'h1234, 16'h0000, 1'b1};
    vecs[3] = '{"p1_rd40",   1'b1, 1'b0, 16'd40, 16'h0000, 16'h0000, 1'b1};
    vecs[4] = '{"p0_rd8",    1'b0, 1'b0, 16'd8,  16'h0000, 16'h0808, 1'b0};
    vecs[5] = '{"p1_wr31",   1'b1, 1'b1, 16'd31, 16'hA5A5, 16'h0000, 1'b0};
    vecs[6] = '{"p0_rd31",   1'b0, 1'b0, 16'd31, 16'h0000, 16'hA5A5, 1'b0};
    vecs[7] = '{"p1_rd32",   1'b1, 1'b0, 16'd32, 16'h0000, 16'h0000, 1'b1};
    vecs[8] = '{"p0_wr0",    1'b0, 1'b1, 16'd0,  16'h0F0F, 16'h0000, 1'b0};
    vecs[9] = '{"p1_rd0",    1'b1, 1'b0, 16'd0,  16'h0000, 16'h0F0F, 1'b0};

    // reset
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 0;
    @(negedge clk);
    check_reset_vals("post_reset_idle");
    mon_en = 1;

    // simultaneous requests right after reset: port 0 first
    gnt_exp_q = '{1'b0, 1'b1};
    rd0_exp_q = '{16'h1111};
    rd1_exp_q = '{16'h2222};
    run_seq("tie", 1, 1, 1'b0, 16'd1, 16'h0, 1'b0, 16'd2, 16'h0, 40);

    // table-driven single transactions
    for (int i = 0; i < 10; i++)
      do_txn(vecs[i].name, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err);

    // continuous requests from both ports: strict alternation starting at port 0
    gnt_exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    rd0_exp_q = '{16'h1111, 16'h1111, 16'h1111};
    rd1_exp_q = '{16'h2222, 16'h2222, 16'h2222};
    run_seq("alt", 3, 3, 1'b0, 16'd1, 16'h0, 1'b0, 16'd2, 16'h0, 100);

    // back-to-back: port 1 write granted the cycle after port 0's rvalid
    gnt_exp_q = '{1'b0, 1'b1};
    rd0_exp_q = '{16'h3333};
    run_seq("b2b", 1, 1, 1'b0, 16'd3, 16'h0, 1'b1, 16'd10, 16'hCAFE, 40);
    chk("b2b_gnt1_after_rvalid0", g1_cyc - rv0_cyc, 1);
    do_txn("b2b_readback", 1'b0, 1'b0, 16'd10, 16'h0, 16'hCAFE, 1'b0);

    // reset during RESP of a port 0 read
    req0 = 1; we0 = 0; addr0 = 16'd5; wdata0 = 16'h0;
    @(negedge clk);
    chk("rstmid_gnt0", gnt0, 1);
    req0 = 0;
    @(negedge clk);
    chk("rstmid_in_resp", state_dbg, RESP);
    rst = 1;
    @(negedge clk);
    check_reset_vals("rstmid");
    rst = 0;
    @(negedge clk);
    chk("rstmid_no_rvalid", {rvalid1, rvalid0}, 0);
    chk("rstmid_idle", state_dbg, IDLE);
    do_txn("after_rst_rd5", 1'b1, 1'b0, 16'd5, 16'h0, 16'hBEEF, 1'b0);

    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
